frame_uart_sender: RTL and testbench
====================================

FRAME_UART_SENDER -- requirements
Module: frame_uart_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter FRAME_PIXELS, default 9216, bytes per frame (96x96, 8-bit pixels).
REQ-003 Parameter ADDR_W, default 15, frame-RAM address width.
REQ-004 i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Start  input  1  one-cycle request to transmit one stored frame.
REQ-007 i_RAM_Data  input  8  frame-RAM read data.
REQ-008 o_RAM_Adress  output  ADDR_W  frame-RAM read address, registered.
REQ-009 o_RAM_Read_Enable  output  1  frame-RAM read strobe, registered.
REQ-010 o_Tx  output  1  UART 8N1 serial line, idle high.
REQ-011 o_Busy  output  1  high from accepted i_Start until o_Done.
REQ-012 o_Done  output  1  one-cycle pulse after the last stop bit of a frame.

Function
REQ-013 Frame format: header 0xAA, header 0x55, then FRAME_PIXELS bytes from addresses 0..FRAME_PIXELS-1 in ascending order.
REQ-014 UART byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles; no idle gap required between bytes.
REQ-015 States: IDLE, HDR0, HDR1, FETCH, WAIT_RAM, LOAD, SEND, DONE.
REQ-016 IDLE: i_Start=1 -> HDR0, o_Busy=1, pixel counter=0; otherwise remain; i_Start ignored in every other state.
REQ-017 HDR0/HDR1: hand 0xAA/0x55 to byte transmitter; advance when its byte completes (HDR0->HDR1->FETCH).
REQ-018 FETCH: o_RAM_Adress=counter, o_RAM_Read_Enable=1 for exactly one cycle -> WAIT_RAM.
REQ-019 RAM read latency: i_RAM_Data valid two rising edges after the edge on which o_RAM_Read_Enable is registered high; WAIT_RAM lasts one cycle; LOAD captures i_RAM_Data into the transmit register.
REQ-020 LOAD -> SEND; SEND holds until byte complete; then counter=FRAME_PIXELS-1 -> DONE, else counter+1 -> FETCH.
REQ-021 o_RAM_Read_Enable=0 in every state except FETCH; o_RAM_Adress holds its last value otherwise.
REQ-022 Pixel counter ADDR_W bits; never exceeds FRAME_PIXELS-1; returns to 0 on next accepted i_Start (no wrap into a second frame).
REQ-023 DONE: o_Done=1, o_Busy=0 for one cycle -> IDLE; i_Start in DONE cycle ignored; i_Start first honoured the cycle after.
REQ-024 o_Tx=1 whenever no byte is in flight (IDLE, DONE, FETCH, WAIT_RAM, LOAD between bytes).
REQ-025 Byte transmitter accepts a byte only when idle; a load while busy shall not occur by construction.

Reset
REQ-026 On i_Rst=1, asynchronously: state IDLE, o_Tx=1, o_Busy=0, o_Done=0, o_RAM_Read_Enable=0, o_RAM_Adress=0, counters and baud counter 0.
REQ-027 Reset mid-frame abandons the frame; after release, block waits in IDLE for new i_Start and restarts from header.

Structure
REQ-028 Shared package holds state encoding, header constants 0xAA/0x55, default CLKS_PER_BIT and FRAME_PIXELS; the capture block uses the same FRAME_PIXELS.
REQ-029 One sub-module uart_tx_byte (inputs i_Clk, i_Rst, load strobe, 8-bit data; outputs o_Tx, busy, one-cycle byte-done pulse); FSM and RAM addressing stay in frame_uart_sender.

Verification (bench: CLKS_PER_BIT=4, FRAME_PIXELS=4, RAM model with REQ-019 latency, contents 0x10,0x20,0x30,0x40)
REQ-030 Reset asserted then released, no i_Start for 100 cycles -> o_Tx=1, o_Busy=0, o_RAM_Read_Enable=0 throughout.
REQ-031 Single i_Start -> serial decode yields AA 55 10 20 30 40, each bit 4 cycles, LSB first; addresses 0,1,2,3 each read once; o_Done pulses once one cycle after last stop bit ends.
REQ-032 i_Start pulsed during HDR1 and during SEND of 0x20 -> ignored; output stream identical to REQ-031.
REQ-033 RAM contents 0xFF,0x00,0x81,0x7E -> decoded bytes match exactly, stop bit high every byte.
REQ-034 i_Rst asserted mid-start-bit of pixel 0x30 -> o_Tx high same cycle asynchronously; new i_Start after release -> full stream from AA restarts at address 0.
REQ-035 i_Start on o_Done cycle ignored, i_Start next cycle accepted -> second complete frame, addresses restart at 0.

Source files
------------

// File: rtl/frame_uart_sender_pkg.sv
// Shared definitions for the frame UART sender: state encodings,
// frame header bytes and default timing/frame-size parameters.
package frame_uart_sender_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
  localparam int DEFAULT_FRAME_PIXELS = 9216;  // 96x96, 8-bit pixels
  localparam int DEFAULT_ADDR_W       = 15;

  localparam logic [7:0] HDR0_BYTE = 8'hAA;
  localparam logic [7:0] HDR1_BYTE = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_FETCH,
    S_WAIT_RAM,
    S_LOAD,
    S_SEND,
    S_DONE
  } frame_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/frame_uart_sender_tx_byte.sv
// 8N1 UART byte transmitter. Accepts a byte only while idle, shifts it
// out LSB first and raises o_Done during the final cycle of the stop bit
// so the caller can hand over the next byte right after it.
module uart_tx_byte
  import frame_uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Load,
  input  logic [7:0] i_Data,
  output logic       o_Tx,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  tx_state_t        next_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_end;

  assign bit_end = (baud_cnt == LAST_CNT);
  assign o_Busy  = (state != TX_IDLE);
  assign o_Done  = (state == TX_STOP) && bit_end;

  // Transmitter state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= TX_IDLE;
    else       state <= next_state;
  end

  // Bit-phase sequencing: start bit, eight data bits, stop bit.
  always_comb begin
    next_state = state;
    case (state)
      TX_IDLE:  if (i_Load) next_state = TX_START;
      TX_START: if (bit_end) next_state = TX_DATA;
      TX_DATA:  if (bit_end && (bit_idx == 3'd7)) next_state = TX_STOP;
      TX_STOP:  if (bit_end) next_state = TX_IDLE;
      default:  next_state = TX_IDLE;
    endcase
  end

  // Baud counter, bit index, shift register and the registered line level.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
      o_Tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          if (i_Load) begin
            shift_reg <= i_Data;
            o_Tx      <= 1'b0;
          end else begin
            o_Tx <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            o_Tx     <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_Tx <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              o_Tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          o_Tx <= 1'b1;
          if (bit_end) baud_cnt <= '0;
          else         baud_cnt <= baud_cnt + 1'b1;
        end
        default: begin
          baud_cnt <= '0;
          o_Tx     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_uart_sender.sv
// Streams one stored frame over UART on request: two header bytes
// followed by every pixel byte read from the frame RAM in address order.
module frame_uart_sender
  import frame_uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
  parameter int ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [7:0]        i_RAM_Data,
  output logic [ADDR_W-1:0] o_RAM_Adress,
  output logic              o_RAM_Read_Enable,
  output logic              o_Tx,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(FRAME_PIXELS - 1);

  frame_state_t      state;
  frame_state_t      next_state;
  logic [ADDR_W-1:0] pixel_cnt;
  logic [ADDR_W-1:0] pixel_next;
  logic              tx_load;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;

  assign o_Busy = (state != S_IDLE) && (state != S_DONE);
  assign o_Done = (state == S_DONE);

  // Frame sequencer state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= next_state;
  end

  // Sequencing of headers, RAM fetches and pixel transmission.
  always_comb begin
    next_state = state;
    pixel_next = pixel_cnt;
    tx_load    = 1'b0;
    tx_data    = HDR0_BYTE;
    case (state)
      S_IDLE: begin
        if (i_Start) begin
          next_state = S_HDR0;
          pixel_next = '0;
        end
      end
      S_HDR0: begin
        tx_data = HDR0_BYTE;
        tx_load = !tx_busy;
        if (tx_done) next_state = S_HDR1;
      end
      S_HDR1: begin
        tx_data = HDR1_BYTE;
        tx_load = !tx_busy;
        if (tx_done) next_state = S_FETCH;
      end
      S_FETCH:    next_state = S_WAIT_RAM;
      S_WAIT_RAM: next_state = S_LOAD;
      S_LOAD: begin
        tx_data    = i_RAM_Data;
        tx_load    = 1'b1;
        next_state = S_SEND;
      end
      S_SEND: begin
        if (tx_done) begin
          if (pixel_cnt == LAST_PIXEL) begin
            next_state = S_DONE;
          end else begin
            pixel_next = pixel_cnt + 1'b1;
            next_state = S_FETCH;
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Pixel counter plus registered RAM address and one-cycle read strobe.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pixel_cnt         <= '0;
      o_RAM_Adress      <= '0;
      o_RAM_Read_Enable <= 1'b0;
    end else begin
      pixel_cnt         <= pixel_next;
      o_RAM_Read_Enable <= (next_state == S_FETCH);
      if (next_state == S_FETCH) o_RAM_Adress <= pixel_next;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Load (tx_load),
    .i_Data (tx_data),
    .o_Tx   (o_Tx),
    .o_Busy (tx_busy),
    .o_Done (tx_done)
  );

endmodule

// File: tb/tb_frame_uart_sender.sv
// Bench for frame_uart_sender: decodes the serial line bit by bit and
// compares it with the frame expected from the RAM contents.
module tb_frame_uart_sender;

  localparam int CLKS = 4;
  localparam int PIX  = 4;
  localparam int AW   = 4;

  logic          i_Clk   = 1'b0;
  logic          i_Rst   = 1'b1;
  logic          i_Start = 1'b0;
  logic [7:0]    i_RAM_Data;
  logic [AW-1:0] o_RAM_Adress;
  logic          o_RAM_Read_Enable;
  logic          o_Tx;
  logic          o_Busy;
  logic          o_Done;

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem [0:15];
  logic [7:0]    ram_s1 = 8'd0;
  logic [7:0]    ram_q  = 8'd0;
  int            done_count = 0;
  logic [AW-1:0] reads [$];

  assign i_RAM_Data = ram_q;

  frame_uart_sender #(
    .CLKS_PER_BIT(CLKS),
    .FRAME_PIXELS(PIX),
    .ADDR_W(AW)
  ) dut (
    .i_Clk             (i_Clk),
    .i_Rst             (i_Rst),
    .i_Start           (i_Start),
    .i_RAM_Data        (i_RAM_Data),
    .o_RAM_Adress      (o_RAM_Adress),
    .o_RAM_Read_Enable (o_RAM_Read_Enable),
    .o_Tx              (o_Tx),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  // Frame RAM with data valid two edges after the read strobe is registered.
  always @(posedge i_Clk) begin
    if (o_RAM_Read_Enable) ram_s1 <= mem[o_RAM_Adress];
    ram_q <= ram_s1;
  end

  // Record every RAM read and every done pulse.
  always @(posedge i_Clk) begin
    if (o_Done) done_count++;
    if (o_RAM_Read_Enable) reads.push_back(o_RAM_Adress);
  end

  // Run-time guard against a hung sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic applyStimulus();
    @(negedge i_Clk);
    pulse_start();
  endtask

  task automatic idle_check(input string tag, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      @(negedge i_Clk);
      if ({o_Tx, o_Busy, o_RAM_Read_Enable, o_Done} !== 4'b1000) ok = 1'b0;
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  // Waits for a start bit, then samples every cycle of every bit.
  task automatic decode_byte(input logic [7:0] expected, input string tag);
    bit         found = 1'b0;
    bit         width_ok = 1'b1;
    bit         stop_ok = 1'b1;
    logic [7:0] got = 8'd0;
    logic       smp [4];
    for (int i = 0; i < 200; i++) begin
      @(negedge i_Clk);
      if (o_Tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, " start"}, 32'(found), 32'd1);
    if (!found) return;
    repeat (CLKS - 1) begin
      @(negedge i_Clk);
      if (o_Tx !== 1'b0) width_ok = 1'b0;
    end
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < CLKS; s++) begin
        @(negedge i_Clk);
        smp[s] = o_Tx;
      end
      got[b] = smp[0];
      for (int s = 1; s < CLKS; s++) if (smp[s] !== smp[0]) width_ok = 1'b0;
    end
    repeat (CLKS) begin
      @(negedge i_Clk);
      if (o_Tx !== 1'b1) stop_ok = 1'b0;
    end
    checkOutput({tag, " data"}, 32'(got), 32'(expected));
    checkOutput({tag, " width"}, 32'(width_ok), 32'd1);
    checkOutput({tag, " stop"}, 32'(stop_ok), 32'd1);
  endtask

  // Decodes a whole frame against header + RAM contents. done_mode:
  // 0 nothing after done, 1 start only in the done cycle, 2 start held
  // through the done cycle and the following one.
  task automatic check_frame(input string tag, input bit inject, input int done_mode);
    logic [7:0] exp_bytes [$];
    int read_base;
    int done_base;
    exp_bytes = {8'hAA, 8'h55};
    for (int i = 0; i < PIX; i++) exp_bytes.push_back(mem[i]);
    read_base = reads.size();
    done_base = done_count;
    for (int k = 0; k < exp_bytes.size(); k++) begin
      if (inject && k == 1) begin
        @(negedge i_Clk);
        fork pulse_start(); join_none
      end
      if (inject && k == 3) begin
        fork
          begin
            repeat (10) @(negedge i_Clk);
            pulse_start();
          end
        join_none
      end
      decode_byte(exp_bytes[k], $sformatf("%s byte%0d", tag, k));
      if (k == 0) checkOutput({tag, " busy"}, 32'(o_Busy), 32'd1);
    end
    @(negedge i_Clk);
    checkOutput({tag, " done"}, 32'({o_Done, o_Busy}), 32'b10);
    checkOutput({tag, " nreads"}, 32'(reads.size() - read_base), 32'(PIX));
    for (int i = 0; i < PIX && (read_base + i) < reads.size(); i++)
      checkOutput($sformatf("%s addr%0d", tag, i), 32'(reads[read_base + i]), 32'(i));
    if (done_mode != 0) i_Start = 1'b1;
    @(negedge i_Clk);
    checkOutput({tag, " done_once"}, 32'(done_count - done_base), 32'd1);
    checkOutput({tag, " done_low"}, 32'(o_Done), 32'd0);
    if (done_mode == 1) begin
      i_Start = 1'b0;
      idle_check({tag, " start_in_done_ignored"}, 20);
    end else if (done_mode == 2) begin
      @(negedge i_Clk);
      i_Start = 1'b0;
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    $display("[TB] reset and idle");
    repeat (3) @(negedge i_Clk);
    checkOutput("reset outputs", 32'({o_Tx, o_Busy, o_RAM_Read_Enable, o_Done}), 32'b1000);
    checkOutput("reset addr", 32'(o_RAM_Adress), 32'd0);
    i_Rst = 1'b0;
    idle_check("idle 100", 100);

    $display("[TB] basic frame");
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    applyStimulus();
    check_frame("basic", 1'b0, 0);

    $display("[TB] start pulses while busy");
    applyStimulus();
    check_frame("ignore", 1'b1, 0);

    $display("[TB] edge pixel values and start in done");
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h81; mem[3] = 8'h7E;
    applyStimulus();
    check_frame("edge", 1'b0, 1);
    applyStimulus();
    check_frame("edge2", 1'b0, 2);
    check_frame("back2back", 1'b0, 0);

    $display("[TB] reset mid-frame");
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    applyStimulus();
    decode_byte(8'hAA, "abort byte0");
    decode_byte(8'h55, "abort byte1");
    decode_byte(8'h10, "abort byte2");
    decode_byte(8'h20, "abort byte3");
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_Clk);
      if (o_Tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort start 0x30", 32'(found), 32'd1);
    #2;
    i_Rst = 1'b1;
    #1;
    checkOutput("async reset outputs", 32'({o_Tx, o_Busy, o_RAM_Read_Enable, o_Done}), 32'b1000);
    checkOutput("async reset addr", 32'(o_RAM_Adress), 32'd0);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    idle_check("idle after reset", 20);
    applyStimulus();
    check_frame("restart", 1'b0, 0);

    $display("[TB] random frames");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < PIX; i++) mem[i] = 8'($urandom);
      repeat ($urandom_range(1, 20)) @(negedge i_Clk);
      applyStimulus();
      check_frame($sformatf("rand%0d", r), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
